dice_roll_ctrl: RTL and testbench

//  Sequences one dice roll around the face-range decoder (NB_Face -> Min/Max).

---
 rtl/dice_roll_if.sv | 23 ++
 rtl/dice_roll_ctrl.sv | 126 ++++++++++++
 tb/tb_dice_roll_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dice_roll_if.sv
// Signal bundle between the dice roll sequencer, its face-range decoder and the display side.
// master = sequencer, slave = decoder/display/button side.
interface dice_roll_if;
  logic       Lancer;
  logic [6:0] NB_Face;
  logic [6:0] Min;
  logic [6:0] Max;
  logic [6:0] NB_Face_Sel;
  logic [6:0] Valeur;
  logic       Roulement;
  logic       Valide;
  logic       Fin;

  modport master (
    input  Lancer, NB_Face, Min, Max,
    output NB_Face_Sel, Valeur, Roulement, Valide, Fin
  );

  modport slave (
    output Lancer, NB_Face, Min, Max,
    input  NB_Face_Sel, Valeur, Roulement, Valide, Fin
  );
endinterface

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: latches the face count, spins the value while the button is held,
// then decelerates with doubling step intervals and holds the final value.
module dice_roll_ctrl #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned MIN_ROLL    = 8,
  parameter int unsigned DECEL_STEPS = 6
) (
  input logic          clk,
  input logic          rst,
  dice_roll_if.master  bus
);

  localparam int unsigned PreW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RollW = $clog2(MIN_ROLL + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRoll, StDecel, StShow} state_e;

  state_e           r_state_q, r_state_d;
  logic [PreW-1:0]  r_pre_q, r_pre_d;
  logic [RollW-1:0] r_roll_q, r_roll_d;
  logic [2:0]       r_k_q, r_k_d;
  logic [6:0]       r_wait_q, r_wait_d;
  logic [6:0]       r_sel_q, r_sel_d;
  logic [6:0]       r_val_q, r_val_d;
  logic             r_fin_q, r_fin_d;
  logic             r_lancer_q;

  logic       w_press;
  logic       w_tick;
  logic [6:0] w_step_val;
  logic [6:0] w_wait_lim;

  assign w_press    = bus.Lancer & ~r_lancer_q;
  assign w_tick     = (r_pre_q == PreW'(TICK_DIV - 1));
  // >= rather than == so a stale out-of-range value snaps back into the new range
  assign w_step_val = (r_val_q >= bus.Max) ? bus.Min : r_val_q + 7'd1;
  assign w_wait_lim = 7'((8'd1 << r_k_q) - 8'd1);

  always_comb begin
    r_state_d = r_state_q;
    r_pre_d   = '0;
    r_roll_d  = r_roll_q;
    r_k_d     = r_k_q;
    r_wait_d  = r_wait_q;
    r_sel_d   = r_sel_q;
    r_val_d   = r_val_q;
    r_fin_d   = 1'b0;

    unique case (r_state_q)
      StIdle, StShow: begin
        if (w_press) begin
          r_sel_d   = bus.NB_Face;
          r_state_d = StLoad;
        end
      end
      StLoad: begin
        r_val_d   = bus.Min;
        r_roll_d  = '0;
        r_state_d = StRoll;
      end
      StRoll: begin
        r_pre_d = w_tick ? '0 : r_pre_q + PreW'(1);
        if (w_tick) begin
          r_val_d = w_step_val;
          if (r_roll_q != RollW'(MIN_ROLL)) r_roll_d = r_roll_q + RollW'(1);
        end
        if (!bus.Lancer && r_roll_d == RollW'(MIN_ROLL)) begin
          r_k_d     = '0;
          r_wait_d  = '0;
          r_state_d = StDecel;
        end
      end
      StDecel: begin
        r_pre_d = w_tick ? '0 : r_pre_q + PreW'(1);
        if (w_press) begin
          r_state_d = StRoll;
        end else if (w_tick) begin
          if (r_wait_q == w_wait_lim) begin
            r_val_d  = w_step_val;
            r_wait_d = '0;
            r_k_d    = r_k_q + 3'd1;
            if (r_k_q == 3'(DECEL_STEPS - 1)) begin
              r_state_d = StShow;
              r_fin_d   = 1'b1;
            end
          end else begin
            r_wait_d = r_wait_q + 7'd1;
          end
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= StIdle;
      r_pre_q    <= '0;
      r_roll_q   <= '0;
      r_k_q      <= '0;
      r_wait_q   <= '0;
      r_sel_q    <= 7'd6;
      r_val_q    <= '0;
      r_fin_q    <= 1'b0;
      r_lancer_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_pre_q    <= r_pre_d;
      r_roll_q   <= r_roll_d;
      r_k_q      <= r_k_d;
      r_wait_q   <= r_wait_d;
      r_sel_q    <= r_sel_d;
      r_val_q    <= r_val_d;
      r_fin_q    <= r_fin_d;
      r_lancer_q <= bus.Lancer;
    end
  end

  assign bus.NB_Face_Sel = r_sel_q;
  assign bus.Valeur      = r_val_q;
  assign bus.Roulement   = (r_state_q == StLoad) || (r_state_q == StRoll) ||
                           (r_state_q == StDecel);
  assign bus.Valide      = (r_state_q == StShow);
  assign bus.Fin         = r_fin_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with a behavioural face-range decoder.
module tb_dice_roll_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dice_roll_if bus ();

  dice_roll_ctrl #(
    .TICK_DIV    (4),
    .MIN_ROLL    (4),
    .DECEL_STEPS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.Min = 7'd1;
    bus.Max = 7'd6;
    case (bus.NB_Face_Sel)
      7'd4:   bus.Max = 7'd4;
      7'd8:   bus.Max = 7'd8;
      7'd12:  bus.Max = 7'd12;
      7'd20:  bus.Max = 7'd20;
      7'd30:  bus.Max = 7'd30;
      7'd10:  begin bus.Min = 7'd0; bus.Max = 7'd9;  end
      7'd100: begin bus.Min = 7'd0; bus.Max = 7'd99; end
      default: ;
    endcase
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.Lancer = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Lancer  = 1'b0;
    bus.NB_Face = 7'd6;
    wait_neg(2);
    total++;
    if (bus.NB_Face_Sel !== 7'd6) begin
      bad++; $display("FAIL reset_sel got=%0d want=6", bus.NB_Face_Sel);
    end
    total++;
    if (bus.Valeur !== 7'd0) begin
      bad++; $display("FAIL reset_val got=%0d want=0", bus.Valeur);
    end
    total++;
    if ({bus.Roulement, bus.Valide, bus.Fin} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {bus.Roulement, bus.Valide, bus.Fin});
    end
    rst = 1'b0;
  endtask

  task automatic test_spin();
    bus.NB_Face = 7'd4;
    bus.Lancer  = 1'b1;
    wait_neg(1);
    total++;
    if (bus.Roulement !== 1'b1 || bus.NB_Face_Sel !== 7'd4) begin
      bad++; $display("FAIL spin_load roul=%b sel=%0d want 1/4", bus.Roulement, bus.NB_Face_Sel);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL spin_first got=%0d want=1", bus.Valeur);
    end
    for (int i = 1; i <= 12; i++) begin
      wait_neg(4);
      total++;
      if (bus.Valeur !== 7'((i % 4) + 1) || bus.Roulement !== 1'b1) begin
        bad++;
        $display("FAIL spin_step%0d got=%0d roul=%b want=%0d", i, bus.Valeur, bus.Roulement,
                 (i % 4) + 1);
      end
    end
    do_reset();
  endtask

  task automatic test_wrap();
    bus.NB_Face = 7'd10;
    bus.Lancer  = 1'b1;
    wait_neg(2);
    total++;
    if (bus.Valeur !== 7'd0) begin
      bad++; $display("FAIL wrap10_first got=%0d want=0", bus.Valeur);
    end
    for (int i = 1; i <= 10; i++) begin
      wait_neg(4);
      total++;
      if (bus.Valeur !== 7'(i % 10)) begin
        bad++; $display("FAIL wrap10_step%0d got=%0d want=%0d", i, bus.Valeur, i % 10);
      end
    end
    do_reset();
    bus.NB_Face = 7'd100;
    bus.Lancer  = 1'b1;
    wait_neg(2);
    for (int i = 1; i <= 100; i++) begin
      wait_neg(4);
      if (i >= 99) begin
        total++;
        if (bus.Valeur !== 7'(i % 100)) begin
          bad++; $display("FAIL wrap100_step%0d got=%0d want=%0d", i, bus.Valeur, i % 100);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_decel();
    bus.NB_Face = 7'd6;
    bus.Lancer  = 1'b1;
    wait_neg(2);
    wait_neg(20);
    total++;
    if (bus.Valeur !== 7'd6) begin
      bad++; $display("FAIL decel_pre got=%0d want=6", bus.Valeur);
    end
    bus.Lancer = 1'b0;
    wait_neg(3);
    total++;
    if (bus.Valeur !== 7'd6 || bus.Roulement !== 1'b1) begin
      bad++; $display("FAIL decel_hold0 got=%0d roul=%b want 6/1", bus.Valeur, bus.Roulement);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL decel_step1 got=%0d want=1", bus.Valeur);
    end
    wait_neg(7);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL decel_hold1 got=%0d want=1", bus.Valeur);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd2) begin
      bad++; $display("FAIL decel_step2 got=%0d want=2", bus.Valeur);
    end
    wait_neg(15);
    total++;
    if (bus.Valeur !== 7'd2 || bus.Valide !== 1'b0 || bus.Fin !== 1'b0) begin
      bad++;
      $display("FAIL decel_hold2 got=%0d valide=%b fin=%b want 2/0/0", bus.Valeur, bus.Valide,
               bus.Fin);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd3 || {bus.Fin, bus.Valide, bus.Roulement} !== 3'b110) begin
      bad++;
      $display("FAIL decel_show got=%0d fin/valide/roul=%b want 3/110", bus.Valeur,
               {bus.Fin, bus.Valide, bus.Roulement});
    end
    wait_neg(1);
    total++;
    if (bus.Fin !== 1'b0 || bus.Valide !== 1'b1) begin
      bad++; $display("FAIL fin_pulse fin=%b valide=%b want 0/1", bus.Fin, bus.Valide);
    end
    wait_neg(11);
    total++;
    if (bus.Valeur !== 7'd3 || bus.Valide !== 1'b1) begin
      bad++; $display("FAIL show_frozen got=%0d valide=%b want 3/1", bus.Valeur, bus.Valide);
    end
  endtask

  task automatic test_back_to_back();
    bus.NB_Face = 7'd4;
    bus.Lancer  = 1'b1;
    wait_neg(1);
    total++;
    if (bus.Valide !== 1'b0 || bus.Roulement !== 1'b1 || bus.NB_Face_Sel !== 7'd4) begin
      bad++;
      $display("FAIL b2b_load valide=%b roul=%b sel=%0d want 0/1/4", bus.Valide, bus.Roulement,
               bus.NB_Face_Sel);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL b2b_min got=%0d want=1", bus.Valeur);
    end
    do_reset();
  endtask

  task automatic test_short_press();
    bus.NB_Face = 7'd6;
    bus.Lancer  = 1'b1;
    wait_neg(1);
    bus.Lancer = 1'b0;
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL short_min got=%0d want=1", bus.Valeur);
    end
    wait_neg(16);
    total++;
    if (bus.Valeur !== 7'd5 || bus.Roulement !== 1'b1) begin
      bad++; $display("FAIL short_roll got=%0d roul=%b want 5/1", bus.Valeur, bus.Roulement);
    end
    wait_neg(4);
    total++;
    if (bus.Valeur !== 7'd6) begin
      bad++; $display("FAIL short_d1 got=%0d want=6", bus.Valeur);
    end
    wait_neg(8);
    total++;
    if (bus.Valeur !== 7'd1) begin
      bad++; $display("FAIL short_d2 got=%0d want=1", bus.Valeur);
    end
    wait_neg(15);
    total++;
    if (bus.Valeur !== 7'd1 || bus.Valide !== 1'b0) begin
      bad++; $display("FAIL short_hold got=%0d valide=%b want 1/0", bus.Valeur, bus.Valide);
    end
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd2 || bus.Fin !== 1'b1 || bus.Valide !== 1'b1) begin
      bad++;
      $display("FAIL short_final got=%0d fin=%b valide=%b want 2/1/1", bus.Valeur, bus.Fin,
               bus.Valide);
    end
    do_reset();
  endtask

  task automatic test_mid_change();
    bus.NB_Face = 7'd6;
    bus.Lancer  = 1'b1;
    wait_neg(1);
    bus.NB_Face = 7'd20;
    wait_neg(1);
    total++;
    if (bus.Valeur !== 7'd1 || bus.NB_Face_Sel !== 7'd6) begin
      bad++; $display("FAIL mid_first got=%0d sel=%0d want 1/6", bus.Valeur, bus.NB_Face_Sel);
    end
    for (int i = 1; i <= 10; i++) begin
      wait_neg(4);
      total++;
      if (bus.Valeur !== 7'((i % 6) + 1) || bus.NB_Face_Sel !== 7'd6) begin
        bad++;
        $display("FAIL mid_step%0d got=%0d sel=%0d want %0d/6", i, bus.Valeur, bus.NB_Face_Sel,
                 (i % 6) + 1);
      end
    end
    bus.Lancer = 1'b0;
    wait_neg(6);
    bus.Lancer = 1'b1;
    wait_neg(40);
    total++;
    if (bus.Valide !== 1'b0 || bus.Roulement !== 1'b1) begin
      bad++; $display("FAIL decel_repress valide=%b roul=%b want 0/1", bus.Valide, bus.Roulement);
    end
    bus.Lancer = 1'b0;
    wait_neg(6);
    rst = 1'b1;
    wait_neg(1);
    total++;
    if ({bus.Valide, bus.Roulement, bus.Fin} !== 3'b000 || bus.Valeur !== 7'd0 ||
        bus.NB_Face_Sel !== 7'd6) begin
      bad++;
      $display("FAIL mid_rst flags=%b val=%0d sel=%0d want 000/0/6",
               {bus.Valide, bus.Roulement, bus.Fin}, bus.Valeur, bus.NB_Face_Sel);
    end
    rst = 1'b0;
    wait_neg(1);
  endtask

  initial begin
    bus.Lancer  = 1'b0;
    bus.NB_Face = 7'd6;
    test_reset();
    test_spin();
    test_wrap();
    test_decel();
    test_back_to_back();
    test_short_press();
    test_mid_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
